// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-wide RAM arbiter: FSM state and requester (owner) encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StResp = 2'd3
  } state_e;

  typedef enum logic {
    OwnF = 1'b0,
    OwnE = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational 2-way grant between prefetch (F) and execution unit (E).
// MEM_ARB_RR_EN selects round-robin on contention; otherwise fixed E-over-F priority.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic   f_req_i,
  input  logic   e_req_i,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_owner_i,
`endif
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  always_comb begin
    gnt_valid_o = f_req_i | e_req_i;
    gnt_owner_o = OwnF;
`ifdef MEM_ARB_RR_EN
    if (f_req_i && e_req_i) begin
      // Contended: whoever did not win last time goes now.
      gnt_owner_o = (last_owner_i == OwnE) ? OwnF : OwnE;
    end else if (e_req_i) begin
      gnt_owner_o = OwnE;
    end
`else
    if (e_req_i) begin
      gnt_owner_o = OwnE;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a byte-wide single-port RAM between prefetch (F) and EU (E), splitting 16-bit accesses
// into two little-endian byte cycles. Define MEM_ARB_RR_EN for round-robin grant on contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic              f_word,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [15:0]       f_rdata,
  output logic              f_done,
  input  logic              e_req,
  input  logic              e_we,
  input  logic              e_word,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [15:0]       e_wdata,
  output logic [15:0]       e_rdata,
  output logic              e_done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                word_q, word_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         f_rdata_q, f_rdata_d;
  logic [15:0]         e_rdata_q, e_rdata_d;

  logic                gnt_valid;
  owner_e              gnt_owner;

`ifdef MEM_ARB_RR_EN
  owner_e              last_owner_q, last_owner_d;

  mem_arb_grant u_grant (
    .f_req_i      (f_req),
    .e_req_i      (e_req),
    .last_owner_i (last_owner_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_owner_o  (gnt_owner)
  );
`else
  mem_arb_grant u_grant (
    .f_req_i     (f_req),
    .e_req_i     (e_req),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    word_d    = word_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    f_rdata_d = f_rdata_q;
    e_rdata_d = e_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StLo;
          owner_d = gnt_owner;
`ifdef MEM_ARB_RR_EN
          last_owner_d = gnt_owner;
`endif
          if (gnt_owner == OwnE) begin
            addr_d  = e_addr;
            word_d  = e_word;
            we_d    = e_we;
            wdata_d = e_wdata;
          end else begin
            addr_d  = f_addr;
            word_d  = f_word;
            we_d    = 1'b0;
            wdata_d = 16'h0000;
          end
        end
      end
      StLo: begin
        state_d = word_q ? StHi : StResp;
        // Upper byte cleared here; a word access overwrites it in StHi.
        if (!we_q) begin
          if (owner_q == OwnE) e_rdata_d = {8'h00, ram_rd_data};
          else                 f_rdata_d = {8'h00, ram_rd_data};
        end
      end
      StHi: begin
        state_d = StResp;
        if (!we_q) begin
          if (owner_q == OwnE) e_rdata_d[15:8] = ram_rd_data;
          else                 f_rdata_d[15:8] = ram_rd_data;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnF;
      addr_q    <= '0;
      word_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      f_rdata_q <= 16'h0000;
      e_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      e_rdata_q <= e_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= OwnF;
    else     last_owner_q <= last_owner_d;
  end
`endif

  logic              active;
  logic              hi;
  logic [ADDR_W-1:0] byte_addr;

  // RAM side decodes from registered state only, never from the request inputs.
  always_comb begin
    hi          = (state_q == StHi);
    active      = (state_q == StLo) || hi;
    byte_addr   = hi ? addr_q + ADDR_W'(1) : addr_q;
    ram_rd_en   = active & ~we_q;
    ram_wr_en   = active & we_q;
    ram_rd_addr = ram_rd_en ? byte_addr : '0;
    ram_wr_addr = ram_wr_en ? byte_addr : '0;
    ram_wr_data = ram_wr_en ? (hi ? wdata_q[15:8] : wdata_q[7:0]) : 8'h00;
    f_done      = (state_q == StResp) && (owner_q == OwnF);
    e_done      = (state_q == StResp) && (owner_q == OwnE);
    f_rdata     = f_rdata_q;
    e_rdata     = e_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural byte RAM model.
module tb_mem_arbiter;

  localparam int unsigned AW = 20;

  logic          clk;
  logic          rst;
  logic          f_req, f_word;
  logic [AW-1:0] f_addr;
  logic [15:0]   f_rdata;
  logic          f_done;
  logic          e_req, e_we, e_word;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wdata, e_rdata;
  logic          e_done;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [7:0]    ram_rd_data, ram_wr_data;

  logic [7:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;
  int overlaps = 0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req       (f_req),
    .f_word      (f_word),
    .f_addr      (f_addr),
    .f_rdata     (f_rdata),
    .f_done      (f_done),
    .e_req       (e_req),
    .e_we        (e_we),
    .e_word      (e_word),
    .e_addr      (e_addr),
    .e_wdata     (e_wdata),
    .e_rdata     (e_rdata),
    .e_done      (e_done),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rd_data = mem[ram_rd_addr];

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  always @(negedge clk) begin
    if (ram_rd_en && ram_wr_en) overlaps++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one E transaction; lat is the done cycle counted from the IDLE sample cycle (-1 = none).
  task automatic e_xact(input logic we, input logic word, input logic [AW-1:0] addr,
                        input logic [15:0] wdata, output int lat, output int wr_cycles,
                        output logic [AW-1:0] first_wr_addr);
    e_req = 1'b1; e_we = we; e_word = word; e_addr = addr; e_wdata = wdata;
    lat = -1; wr_cycles = 0; first_wr_addr = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ram_wr_en) begin
        if (wr_cycles == 0) first_wr_addr = ram_wr_addr;
        wr_cycles++;
      end
      if (e_done) begin
        lat = n;
        break;
      end
    end
    e_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic f_xact(input logic word, input logic [AW-1:0] addr, output int lat);
    f_req = 1'b1; f_word = word; f_addr = addr;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (f_done) begin
        lat = n;
        break;
      end
    end
    f_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int            lat, wc, fl, el, nd, done_seen;
  logic [AW-1:0] wa, hi_addr;
  int            order [4];
  int            exp_order [4];

  initial begin
    rst = 1'b1;
    f_req = 1'b0; f_word = 1'b0; f_addr = '0;
    e_req = 1'b0; e_we = 1'b0; e_word = 1'b0; e_addr = '0; e_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check_eq("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("rst_dones", 32'({f_done, e_done}), 32'd0);
    check_eq("rst_rdata", {f_rdata, e_rdata}, 32'd0);
    check_eq("rst_addrs", 32'({ram_rd_addr, ram_wr_addr} != '0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload a few bytes through the DUT itself.
    e_xact(1'b1, 1'b0, 20'h00200, 16'h0011, lat, wc, wa);
    e_xact(1'b1, 1'b0, 20'h00201, 16'h0077, lat, wc, wa);
    e_xact(1'b1, 1'b0, 20'h12346, 16'h005A, lat, wc, wa);

    // Byte write (upper byte of wdata must be ignored) then byte read.
    e_xact(1'b1, 1'b0, 20'h12345, 16'hFFA5, lat, wc, wa);
    check_eq("t1_wr_lat", 32'(lat), 32'd2);
    check_eq("t1_wr_cycles", 32'(wc), 32'd1);
    check_eq("t1_wr_addr", 32'(wa), 32'h12345);
    check_eq("t1_mem", 32'(mem[20'h12345]), 32'hA5);
    check_eq("t1_mem_next", 32'(mem[20'h12346]), 32'h5A);
    e_xact(1'b0, 1'b0, 20'h12345, 16'h0000, lat, wc, wa);
    check_eq("t1_rd_lat", 32'(lat), 32'd2);
    check_eq("t1_rdata", 32'(e_rdata), 32'h00A5);

    // Word write then F word read.
    e_xact(1'b1, 1'b1, 20'h00100, 16'hBEEF, lat, wc, wa);
    check_eq("t2_wr_lat", 32'(lat), 32'd3);
    check_eq("t2_wr_cycles", 32'(wc), 32'd2);
    check_eq("t2_mem_lo", 32'(mem[20'h00100]), 32'hEF);
    check_eq("t2_mem_hi", 32'(mem[20'h00101]), 32'hBE);
    f_xact(1'b1, 20'h00100, lat);
    check_eq("t2_f_lat", 32'(lat), 32'd3);
    check_eq("t2_f_rdata", 32'(f_rdata), 32'hBEEF);
    e_xact(1'b0, 1'b1, 20'h00100, 16'h0000, lat, wc, wa);
    check_eq("t2_e_word", 32'(e_rdata), 32'hBEEF);
    e_xact(1'b0, 1'b0, 20'h12345, 16'h0000, lat, wc, wa);
    check_eq("t2_byte_upper_clr", 32'(e_rdata), 32'h00A5);

    // Word write across the top of the address space.
    e_xact(1'b1, 1'b1, 20'hFFFFF, 16'h1234, lat, wc, wa);
    check_eq("t3_mem_top", 32'(mem[20'hFFFFF]), 32'h34);
    check_eq("t3_mem_wrap", 32'(mem[20'h00000]), 32'h12);
    f_xact(1'b1, 20'hFFFFF, lat);
    check_eq("t3_f_rdata", 32'(f_rdata), 32'h1234);

    // Contention: fresh reset so round-robin history starts at F.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef MEM_ARB_RR_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    order = '{9, 9, 9, 9};
    f_word = 1'b0; f_addr = 20'h00100;
    e_we = 1'b0; e_word = 1'b0; e_addr = 20'h12345;
    f_req = 1'b1; e_req = 1'b1;
    nd = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (e_done) begin order[nd] = 1; nd++; end
      else if (f_done) begin order[nd] = 0; nd++; end
      if (nd == 4) break;
    end
    f_req = 1'b0; e_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) check_eq($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // E request arriving while F word read is in its high byte.
    f_word = 1'b1; f_addr = 20'h00100;
    e_we = 1'b0; e_word = 1'b0; e_addr = 20'h12345;
    f_req = 1'b1;
    fl = -1; el = -1; hi_addr = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        hi_addr = ram_rd_addr;
        e_req = 1'b1;
      end
      if (f_done) begin fl = n; f_req = 1'b0; end
      if (e_done) begin el = n; e_req = 1'b0; break; end
    end
    f_req = 1'b0; e_req = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_hi_addr", 32'(hi_addr), 32'h00101);
    check_eq("t5_f_lat", 32'(fl), 32'd3);
    check_eq("t5_f_rdata", 32'(f_rdata), 32'hBEEF);
    check_eq("t5_e_done_cycle", 32'(el), 32'd6);
    check_eq("t5_e_rdata", 32'(e_rdata), 32'h00A5);

    // Reset during the high byte of a word write.
    e_req = 1'b1; e_we = 1'b1; e_word = 1'b1; e_addr = 20'h00200; e_wdata = 16'hCAFE;
    @(posedge clk); #1;
    check_eq("t6_lo_wr", 32'({ram_wr_en, ram_wr_data}), 32'h1FE);
    @(posedge clk); #1;
    check_eq("t6_hi_addr", 32'(ram_wr_addr), 32'h00201);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("t6_rst_done", 32'(e_done), 32'd0);
    check_eq("t6_rst_rdata", {f_rdata, e_rdata}, 32'd0);
    e_req = 1'b0; e_we = 1'b0; e_word = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (e_done || f_done) done_seen++;
    end
    check_eq("t6_no_done", 32'(done_seen), 32'd0);
    check_eq("t6_mem_lo", 32'(mem[20'h00200]), 32'hFE);
    check_eq("t6_mem_hi", 32'(mem[20'h00201]), 32'h77);
    e_xact(1'b0, 1'b0, 20'h00200, 16'h0000, lat, wc, wa);
    check_eq("t6_idle_lat", 32'(lat), 32'd2);
    check_eq("t6_readback", 32'(e_rdata), 32'h00FE);

    check_eq("no_enable_overlap", 32'(overlaps), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
